// File: rtl/pio_bank_irq.sv
// Avalon-MM parallel I/O bank: synchronised, debounced inputs with edge capture and masked irq, set/clear output register.
// Read latency 1, writes take effect on the sampling edge; no waitrequest. Optional debounce via PIO_DEBOUNCE_EN.
module pio_bank_irq #(
    parameter int                   IN_WIDTH        = 16,
    parameter int                   OUT_WIDTH       = 32,
    parameter int                   DEBOUNCE_CYCLES = 50000,
    parameter int                   EDGE_MODE       = 2,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           address,
    input  logic                 read,
    input  logic                 write,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic                 irq,
    input  logic [IN_WIDTH-1:0]  in_port,
    output logic [OUT_WIDTH-1:0] out_port
);

    logic [IN_WIDTH-1:0]  sync1;
    logic [IN_WIDTH-1:0]  stable;
    logic [IN_WIDTH-1:0]  stable_nxt;
    logic [IN_WIDTH-1:0]  rise;
    logic [IN_WIDTH-1:0]  fall;
    logic [IN_WIDTH-1:0]  edge_set;
    logic [IN_WIDTH-1:0]  cap_clr;
    logic [IN_WIDTH-1:0]  edge_cap;
    logic [IN_WIDTH-1:0]  irq_mask;
    logic [OUT_WIDTH-1:0] data_out;
    logic [31:0]          rd_mux;

`ifdef PIO_DEBOUNCE_EN
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [IN_WIDTH-1:0] sync2;
    logic [CW-1:0]       cnt     [IN_WIDTH];
    logic [CW-1:0]       cnt_nxt [IN_WIDTH];

    // A bit flips only after DEBOUNCE_CYCLES consecutive samples disagreeing with the stable value.
    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < IN_WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    stable_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            cnt    <= '{default: '0};
        end else begin
            sync1  <= in_port;
            sync2  <= sync1;
            stable <= stable_nxt;
            cnt    <= cnt_nxt;
        end
    end
`else
    // Without debounce the stable register doubles as the second synchroniser flop.
    assign stable_nxt = sync1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1  <= '0;
            stable <= '0;
        end else begin
            sync1  <= in_port;
            stable <= stable_nxt;
        end
    end
`endif

    assign rise     = stable_nxt & ~stable;
    assign fall     = ~stable_nxt & stable;
    assign edge_set = (EDGE_MODE == 0) ? rise :
                      (EDGE_MODE == 1) ? fall : (rise | fall);
    assign cap_clr  = (write && address == 3'd5) ? writedata[IN_WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux = 32'(stable);
            3'd1:    rd_mux = 32'(data_out);
            3'd4:    rd_mux = 32'(irq_mask);
            3'd5:    rd_mux = 32'(edge_cap);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out <= OUT_RESET;
            irq_mask <= '0;
            edge_cap <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            if (write) begin
                case (address)
                    3'd1:    data_out <= writedata[OUT_WIDTH-1:0];
                    3'd2:    data_out <= data_out | writedata[OUT_WIDTH-1:0];
                    3'd3:    data_out <= data_out & ~writedata[OUT_WIDTH-1:0];
                    3'd4:    irq_mask <= writedata[IN_WIDTH-1:0];
                    default: ;
                endcase
            end
            // A new edge beats a simultaneous write-1-clear.
            edge_cap <= (edge_cap & ~cap_clr) | edge_set;
            irq      <= |(edge_cap & irq_mask);
            if (read) begin
                readdata <= rd_mux;
            end
        end
    end

    assign out_port = data_out;

endmodule

// File: tb/tb_pio_bank_irq.sv
// Directed bench for pio_bank_irq; expectations follow the PIO_DEBOUNCE_EN setting of the build.
module tb_pio_bank_irq;

`ifdef PIO_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [15:0] in_port;
    logic [31:0] out_port;
    logic [31:0] readdata_b;
    logic        irq_b;
    logic [31:0] out_port_b;
    logic [31:0] d;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pio_bank_irq #(
        .IN_WIDTH(16), .OUT_WIDTH(32), .DEBOUNCE_CYCLES(4),
        .EDGE_MODE(0), .OUT_RESET(32'h0000_00A5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .readdata(readdata),
        .irq(irq), .in_port(in_port), .out_port(out_port)
    );

    pio_bank_irq #(
        .IN_WIDTH(16), .OUT_WIDTH(32), .DEBOUNCE_CYCLES(4),
        .EDGE_MODE(2), .OUT_RESET(32'h0000_00A5)
    ) dut_both (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .readdata(readdata_b),
        .irq(irq_b), .in_port(in_port), .out_port(out_port_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        @(negedge clk);
        address   = a;
        writedata = v;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        @(negedge clk);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read    = 1'b0;
        v       = readdata;
    endtask

    initial begin
        reset_n   = 1'b0;
        address   = '0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = '0;
        in_port   = '0;
        tick(3);
        reset_n = 1'b1;
        tick(1);

        check("rst_out_port", out_port, 32'h0000_00A5);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_readdata", readdata, 32'h0);
        rd(3'd0, d); check("rst_rd0", d, 32'h0);
        rd(3'd4, d); check("rst_rd4", d, 32'h0);
        rd(3'd5, d); check("rst_rd5", d, 32'h0);
        rd(3'd6, d); check("rst_rd6", d, 32'h0);

        wr(3'd1, 32'h0F); check("dout_write", out_port, 32'h0000_000F);
        wr(3'd2, 32'hF0); check("out_set", out_port, 32'h0000_00FF);
        wr(3'd3, 32'h0F); check("out_clr", out_port, 32'h0000_00F0);
        rd(3'd1, d);      check("dout_read", d, 32'h0000_00F0);
        wr(3'd6, 32'hFFFF_FFFF);
        rd(3'd6, d);      check("rd6_after_wr", d, 32'h0);

        wr(3'd4, 32'h1);
        rd(3'd4, d);      check("mask_read", d, 32'h1);

`ifdef PIO_DEBOUNCE_EN
        in_port[0] = 1'b1;
        tick(3);
        in_port[0] = 1'b0;
        tick(8);
        rd(3'd0, d);      check("glitch_data_in", d, 32'h0);
        rd(3'd5, d);      check("glitch_edge_cap", d, 32'h0);
        check("glitch_irq", {31'b0, irq}, 32'h0);
`else
        in_port[3] = 1'b1;
        tick(1);
        in_port[3] = 1'b0;
        tick(4);
        rd(3'd5, d);      check("glitch_edge_cap", d, 32'h8);
        rd(3'd0, d);      check("glitch_data_in", d, 32'h0);
        check("glitch_irq_masked", {31'b0, irq}, 32'h0);
        wr(3'd5, 32'hFFFF_FFFF);
        rd(3'd5, d);      check("glitch_cap_cleared", d, 32'h0);
`endif

        // Rising edge on bit 0 with DATA_IN tracked by a continuous read.
        address    = 3'd0;
        read       = 1'b1;
        in_port[0] = 1'b1;
        tick(LAT);
        check("lat_data_in_before", readdata, 32'h0);
        check("lat_irq_before", {31'b0, irq}, 32'h0);
        tick(1);
        check("lat_data_in_after", readdata, 32'h1);
        check("lat_irq_after", {31'b0, irq}, 32'h1);
        check("lat_irq_both", {31'b0, irq_b}, 32'h1);
        read = 1'b0;
        rd(3'd5, d);      check("rise_edge_cap", d, 32'h1);

        wr(3'd5, 32'h1);
        check("clr_irq_lag", {31'b0, irq}, 32'h1);
        tick(1);
        check("clr_irq_drop", {31'b0, irq}, 32'h0);
        check("clr_irq_both", {31'b0, irq_b}, 32'h0);
        rd(3'd5, d);      check("clr_edge_cap", d, 32'h0);

        in_port[0] = 1'b0;
        tick(LAT + 3);
        check("fall_irq_rise_mode", {31'b0, irq}, 32'h0);
        check("fall_irq_both_mode", {31'b0, irq_b}, 32'h1);
        rd(3'd5, d);      check("fall_edge_cap", d, 32'h0);
        wr(3'd5, 32'h1);
        tick(2);

        // Write-1-clear lands on the same edge as the new rising edge.
        in_port[0] = 1'b1;
        tick(LAT - 1);
        address   = 3'd5;
        writedata = 32'h1;
        write     = 1'b1;
        tick(1);
        write = 1'b0;
        tick(1);
        check("collide_irq", {31'b0, irq}, 32'h1);
        rd(3'd5, d);      check("collide_edge_cap", d, 32'h1);
        tick(3);
        check("readdata_hold", readdata, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
